ksa: RTL and testbench

//  RC4 key-scheduling stage. Permutes the 256-byte S memory in place using the secret key,

---
 rtl/ksa_if.sv | 33 +++
 rtl/ksa.sv | 164 ++++++++++++++++
 tb/tb_ksa.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ksa_if.sv
// Handshake and S RAM port bundle shared between the RC4 key-scheduling stage and its environment.
// The slave side is the ksa stage; the master side is the controller plus the S RAM.
interface ksa_if #(
    parameter int KEY_BYTES = 3
);
    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    logic [7:0]             s_addr;
    logic [7:0]             s_rddata;
    logic [7:0]             s_wrdata;
    logic                   s_wren;

    modport master (
        output en,
        output key,
        output s_rddata,
        input  rdy,
        input  s_addr,
        input  s_wrdata,
        input  s_wren
    );

    modport slave (
        input  en,
        input  key,
        input  s_rddata,
        output rdy,
        output s_addr,
        output s_wrdata,
        output s_wren
    );
endinterface

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the S RAM in place using the latched key, six cycles
// per byte (read S[i], add, read S[j], capture, write S[i], write S[j]).
module ksa #(
    parameter int KEY_BYTES = 3
) (
    input  logic  clk,
    input  logic  rst,
    ksa_if.slave  bus
);
    localparam int KEY_W  = 8 * KEY_BYTES;
    localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_I  = 3'd1,
        CALC  = 3'd2,
        RD_J  = 3'd3,
        LAT_J = 3'd4,
        WR_I  = 3'd5,
        WR_J  = 3'd6
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [7:0]          i_r;
    logic [7:0]          i_next_s;
    logic [7:0]          j_r;
    logic [7:0]          j_next_s;
    logic [KIDX_W-1:0]   kidx_r;
    logic [KIDX_W-1:0]   kidx_next_s;
    logic [KEY_W-1:0]    key_r;
    logic [KEY_W-1:0]    key_next_s;
    logic [7:0]          si_r;
    logic [7:0]          si_next_s;
    logic                rdy_r;
    logic                rdy_next_s;
    logic [7:0]          addr_r;
    logic [7:0]          addr_next_s;
    logic [7:0]          wrdata_r;
    logic [7:0]          wrdata_next_s;
    logic                wren_r;
    logic                wren_next_s;

    // Byte 0 is the most significant key byte.
    function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] k,
                                            input logic [KIDX_W-1:0] idx);
        logic [7:0] b;
        b = k[KEY_W-1 -: 8];
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (idx == KIDX_W'(n)) begin
                b = k[8*(KEY_BYTES-n)-1 -: 8];
            end
        end
        return b;
    endfunction

    // Next-state and next-output logic. RAM-port outputs are registered, so each state
    // loads the values the following state must present on the port.
    always_comb begin
        state_next_s  = state_r;
        i_next_s      = i_r;
        j_next_s      = j_r;
        kidx_next_s   = kidx_r;
        key_next_s    = key_r;
        si_next_s     = si_r;
        rdy_next_s    = 1'b0;
        addr_next_s   = addr_r;
        wrdata_next_s = wrdata_r;
        wren_next_s   = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.en && rdy_r) begin
                    key_next_s   = bus.key;
                    i_next_s     = 8'h00;
                    j_next_s     = 8'h00;
                    kidx_next_s  = {KIDX_W{1'b0}};
                    addr_next_s  = 8'h00;
                    rdy_next_s   = 1'b0;
                    state_next_s = RD_I;
                end else begin
                    rdy_next_s   = 1'b1;
                end
            end
            RD_I: begin
                state_next_s = CALC;
            end
            CALC: begin
                // S[i] arrives now; the new j is also the address RD_J must present.
                si_next_s    = bus.s_rddata;
                j_next_s     = j_r + bus.s_rddata + key_byte(key_r, kidx_r);
                addr_next_s  = j_next_s;
                state_next_s = RD_J;
            end
            RD_J: begin
                state_next_s = LAT_J;
            end
            LAT_J: begin
                // S[j] goes straight into the write-data register used by WR_I.
                addr_next_s   = i_r;
                wrdata_next_s = bus.s_rddata;
                wren_next_s   = 1'b1;
                state_next_s  = WR_I;
            end
            WR_I: begin
                addr_next_s   = j_r;
                wrdata_next_s = si_r;
                wren_next_s   = 1'b1;
                state_next_s  = WR_J;
            end
            WR_J: begin
                // rdy stays low for the first IDLE cycle so a held en cannot restart early.
                if (i_r == 8'hFF) begin
                    state_next_s = IDLE;
                end else begin
                    i_next_s     = i_r + 8'd1;
                    addr_next_s  = i_r + 8'd1;
                    if (kidx_r == KIDX_W'(KEY_BYTES - 1)) begin
                        kidx_next_s = {KIDX_W{1'b0}};
                    end else begin
                        kidx_next_s = kidx_r + {{(KIDX_W-1){1'b0}}, 1'b1};
                    end
                    state_next_s = RD_I;
                end
            end
            default: begin
                rdy_next_s   = 1'b1;
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and RAM-port output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            i_r      <= 8'h00;
            j_r      <= 8'h00;
            kidx_r   <= {KIDX_W{1'b0}};
            key_r    <= {KEY_W{1'b0}};
            si_r     <= 8'h00;
            rdy_r    <= 1'b1;
            addr_r   <= 8'h00;
            wrdata_r <= 8'h00;
            wren_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            i_r      <= i_next_s;
            j_r      <= j_next_s;
            kidx_r   <= kidx_next_s;
            key_r    <= key_next_s;
            si_r     <= si_next_s;
            rdy_r    <= rdy_next_s;
            addr_r   <= addr_next_s;
            wrdata_r <= wrdata_next_s;
            wren_r   <= wren_next_s;
        end
    end

    assign bus.rdy      = rdy_r;
    assign bus.s_addr   = addr_r;
    assign bus.s_wrdata = wrdata_r;
    assign bus.s_wren   = wren_r;
endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: 256x8 synchronous RAM model, table of keys with hand-computed first-swap
// writes, a software key-schedule model for final S, plus mid-run key change and reset sequences.
module tb_ksa;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_load = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] exp_s [256];
    logic [7:0] wa [8];
    logic [7:0] wd [8];
    int nw;
    int total = 0;
    int bad = 0;

    ksa_if #(.KEY_BYTES(3)) bus ();
    ksa #(.KEY_BYTES(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // S RAM: 1-cycle read latency, bulk reload to identity on ram_load.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (bus.s_wren) begin
            mem[bus.s_addr] <= bus.s_wrdata;
        end
        bus.s_rddata <= mem[bus.s_addr];
    end

    typedef struct {
        logic [23:0] key;
        logic [7:0]  wi_addr;
        logic [7:0]  wi_data;
        logic [7:0]  wj_addr;
        logic [7:0]  wj_data;
    } vec_t;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic reload();
        @(negedge clk);
        ram_load = 1'b1;
        @(negedge clk);
        ram_load = 1'b0;
    endtask

    task automatic model_ksa(input logic [23:0] k);
        logic [7:0] j;
        logic [7:0] kb;
        logic [7:0] t;
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
        j = 8'h00;
        for (int n = 0; n < 256; n++) begin
            case (n % 3)
                0:       kb = k[23:16];
                1:       kb = k[15:8];
                default: kb = k[7:0];
            endcase
            j = j + exp_s[n] + kb;
            t = exp_s[n];
            exp_s[n] = exp_s[j];
            exp_s[j] = t;
        end
    endtask

    task automatic check_final(input string name, input logic [23:0] k);
        int miss;
        int first;
        logic [255:0] seen;
        model_ksa(k);
        miss = 0;
        first = -1;
        seen = '0;
        for (int n = 0; n < 256; n++) begin
            if (mem[n] !== exp_s[n]) begin
                miss++;
                if (first < 0) first = n;
            end
            seen[mem[n]] = 1'b1;
        end
        check({name, "_final_s_mismatches"}, miss, 0);
        if (miss != 0) $display("  first differing index %0d: got %0d want %0d", first, mem[first], exp_s[first]);
        check({name, "_perm_distinct"}, $countones(seen), 256);
    endtask

    // mode 0: plain run; 1: key change + en pulse at ev_cyc; 2: rst at ev_cyc.
    task automatic run_key(input string name, input logic [23:0] k, input int mode, input int ev_cyc);
        int cycles;
        bit done;
        @(negedge clk);
        bus.key = k;
        bus.en = 1'b1;
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        check({name, "_rdy_drop"}, int'(bus.rdy), 0);
        nw = 0;
        cycles = 0;
        done = 1'b0;
        while (!done && cycles < 3000) begin
            @(negedge clk);
            if (bus.s_wren && nw < 8) begin
                wa[nw] = bus.s_addr;
                wd[nw] = bus.s_wrdata;
                nw++;
            end
            if (mode == 1 && cycles == ev_cyc) begin
                bus.key = 24'hABCDEF;
                bus.en = 1'b1;
            end else begin
                bus.en = 1'b0;
            end
            if (mode == 2 && cycles == ev_cyc) rst = 1'b1;
            @(posedge clk);
            cycles++;
            #1;
            if (mode == 2 && rst) begin
                check({name, "_rst_rdy"}, int'(bus.rdy), 1);
                check({name, "_rst_wren"}, int'(bus.s_wren), 0);
                rst = 1'b0;
                done = 1'b1;
            end else if (bus.rdy) begin
                done = 1'b1;
            end
        end
        bus.en = 1'b0;
        if (!done) check({name, "_timeout"}, cycles, -1);
        else if (mode != 2) check({name, "_latency"}, cycles, 1537);
    endtask

    vec_t vecs [6];

    initial begin
        int wr_cnt;
        vecs[0] = '{24'h010203, 8'h00, 8'h01, 8'h01, 8'h00};
        vecs[1] = '{24'h000000, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{24'h00033C, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{24'hFF0000, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[4] = '{24'h7A1122, 8'h00, 8'h7A, 8'h7A, 8'h00};
        vecs[5] = '{24'h3C5A01, 8'h00, 8'h3C, 8'h3C, 8'h00};

        bus.en = 1'b0;
        bus.key = 24'h000000;
        rst = 1'b1;
        ram_load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ram_load = 1'b0;
        check("reset_rdy", int'(bus.rdy), 1);
        check("reset_wren", int'(bus.s_wren), 0);
        check("reset_addr", int'(bus.s_addr), 0);
        check("reset_wrdata", int'(bus.s_wrdata), 0);
        wr_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.s_wren) wr_cnt++;
        end
        check("idle_no_writes", wr_cnt, 0);

        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            reload();
            run_key(nm, vecs[v].key, 0, 0);
            check({nm, "_wr_i"}, int'({wa[0], wd[0]}), int'({vecs[v].wi_addr, vecs[v].wi_data}));
            check({nm, "_wr_j"}, int'({wa[1], wd[1]}), int'({vecs[v].wj_addr, vecs[v].wj_data}));
            check_final(nm, vecs[v].key);
            if (vecs[v].key == 24'h000000) begin
                // iterations 0 and 1 self-swap; iteration 2 swaps S[2] and S[3]
                check("zero_it1_wr", int'({wa[2], wd[2], wa[3], wd[3]}), int'(32'h01010101));
                check("zero_it2_wr", int'({wa[4], wd[4], wa[5], wd[5]}), int'(32'h02030302));
            end
        end

        reload();
        run_key("busy_en", 24'h00033C, 1, 100);
        check_final("busy_en", 24'h00033C);

        reload();
        run_key("abort", 24'h00033C, 2, 700);
        reload();
        run_key("after_abort", 24'h00033C, 0, 0);
        check_final("after_abort", 24'h00033C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
